// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_pkg
//  Purpose  : Shared ALU control codes, main-decoder ALU classes, FSM state
//             encoding and latency helpers for the registered ALU decoder.
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctrl_pkg;

  // ALU operation codes; the control word zero-extends these to CTRL_W bits
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010,
    ALU_DIV  = 4'b1011
  } alu_ctrl_e;

  // ALU class as produced by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // Handshake FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fsm_state_e;

  // Extra wait cycles for a decoded op: only M-class ops stall, funct3[2]
  // separates the divide/remainder group from the multiply group.
  function automatic int unsigned lat_of(input logic        md,
                                         input logic [2:0]  funct3,
                                         input int unsigned mul_lat,
                                         input int unsigned div_lat);
    if (!md)
      return 0;
    else if (funct3[2])
      return div_lat;
    else
      return mul_lat;
  endfunction

  // Latency counter width: enough to hold the largest (latency-1), never 0
  function automatic int unsigned cnt_width(input int unsigned mul_lat,
                                            input int unsigned div_lat);
    int unsigned max_lat;
    int unsigned w;
    max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
    w       = $clog2(max_lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/alu_ctrl_unit_aludec_ext.sv
`default_nettype none
// ============================================================================
//  Module   : aludec_ext
//  Purpose  : Purely combinational ALU decode of ALUOp/funct3/funct7 into an
//             operation code, M-extension flag, illegal flag and div select.
//  Revision : 1.0  initial release
// ============================================================================
module aludec_ext
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MEXT = 1
) (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic [1:0] alu_op,
  output alu_ctrl_e  code,
  output logic       md_op,
  output logic       illegal,
  output logic       is_div
);

  logic m_en;

  // M-extension decode exists only in builds that enable it
  generate
    if (MEXT != 0) begin : g_mext
      assign m_en = 1'b1;
    end else begin : g_no_mext
      assign m_en = 1'b0;
    end
  endgenerate

  // Decode table; M encodings fall back to base R-type when m_en is low
  always_comb begin
    code    = ALU_ADD;
    md_op   = 1'b0;
    illegal = 1'b0;
    is_div  = 1'b0;
    case (alu_op)
      ALUOP_ADD: begin
        code = ALU_ADD;
      end
      ALUOP_BR: begin
        case (funct3[2:1])
          2'b00: code = ALU_SUB;
          2'b10: code = ALU_SLT;
          2'b11: code = ALU_SLTU;
          default: begin
            code    = ALU_SUB;
            illegal = 1'b1;
          end
        endcase
      end
      ALUOP_RTYPE: begin
        if (m_en && opb5 && funct7b0) begin
          md_op  = 1'b1;
          is_div = funct3[2];
          code   = funct3[2] ? ALU_DIV : ALU_MUL;
        end else begin
          case (funct3)
            3'b000:  code = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end
      end
      default: begin
        // reserved ALU class: harmless ADD, flagged so the core can trap
        code    = ALU_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule : aludec_ext
`default_nettype wire

// File: rtl/alu_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctrl_unit
//  Purpose  : Registered, valid/ready handshaked ALU control decoder with
//             optional RV32M decode and programmable multiply/divide latency.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MEXT    = 1,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              opb5,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              funct7b0,
  input  logic [1:0]        ALUOp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              md_op,
  output logic              illegal,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(MUL_LAT, DIV_LAT);

  // Per-class latencies are fixed at elaboration; only the class is dynamic
  localparam int unsigned MUL_L = lat_of(1'b1, 3'b000, MUL_LAT, DIV_LAT);
  localparam int unsigned DIV_L = lat_of(1'b1, 3'b100, MUL_LAT, DIV_LAT);

  // Counter preloads: the WAIT state lasts (load + 1) cycles
  localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_L == 0) ? '0 : CNT_W'(MUL_L - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = (DIV_L == 0) ? '0 : CNT_W'(DIV_L - 1);

  fsm_state_e        state_q;
  fsm_state_e        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic              md_q;
  logic              illegal_q;

  alu_ctrl_e         dec_code;
  logic              dec_md;
  logic              dec_illegal;
  logic              dec_is_div;
  logic              has_wait;
  logic [CNT_W-1:0]  load_val;
  logic              load;

  aludec_ext #(
    .MEXT (MEXT)
  ) u_dec (
    .opb5     (opb5),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .funct7b0 (funct7b0),
    .alu_op   (ALUOp),
    .code     (dec_code),
    .md_op    (dec_md),
    .illegal  (dec_illegal),
    .is_div   (dec_is_div)
  );

  // Ready depends on state and out_ready only, never on the data inputs
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q == ST_WAIT);

  assign ALUControl = ctrl_q;
  assign md_op      = md_q;
  assign illegal    = illegal_q;

  // Select the wait length of the request currently on the inputs
  always_comb begin
    has_wait = 1'b0;
    load_val = '0;
    if (dec_md) begin
      has_wait = dec_is_div ? (DIV_L != 0) : (MUL_L != 0);
      load_val = dec_is_div ? DIV_LOAD : MUL_LOAD;
    end
  end

  // Next-state and counter logic; an accepted request overrides the step
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) load = 1'b1;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        if (out_ready) begin
          if (in_valid) load    = 1'b1;
          else          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d = has_wait ? ST_WAIT : ST_HOLD;
      cnt_d   = has_wait ? load_val : '0;
    end
  end

  // State and latency counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output register: captured only on accept, so it is stable under stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= '0;
      md_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load) begin
      ctrl_q    <= CTRL_W'(dec_code);
      md_q      <= dec_md;
      illegal_q <= dec_illegal;
    end
  end

endmodule : alu_ctrl_unit
`default_nettype wire

// File: tb/tb_alu_ctrl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctrl_unit
//  Purpose  : Directed self-checking bench for alu_ctrl_unit (default build
//             with MEXT=1, MUL_LAT=3, DIV_LAT=32, plus a MEXT=0 build).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       opb5 = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       funct7b0 = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic       in_ready, out_valid, md_op, illegal, busy;
  logic [3:0] ALUControl;

  logic       m0_in_valid = 1'b0;
  logic       m0_in_ready, m0_out_valid, m0_md_op, m0_illegal, m0_busy;
  logic [3:0] m0_ALUControl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_ctrl_unit #(.CTRL_W(4), .MEXT(1), .MUL_LAT(3), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .ALUControl(ALUControl), .md_op(md_op), .illegal(illegal), .busy(busy)
  );

  alu_ctrl_unit #(.CTRL_W(4), .MEXT(0), .MUL_LAT(3), .DIV_LAT(32)) dut_m0 (
    .clk(clk), .reset(reset), .in_valid(m0_in_valid), .in_ready(m0_in_ready),
    .opb5(opb5), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
    .ALUOp(ALUOp), .out_valid(m0_out_valid), .out_ready(1'b1),
    .ALUControl(m0_ALUControl), .md_op(m0_md_op), .illegal(m0_illegal), .busy(m0_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic b5, input logic [2:0] f3,
                       input logic f7b5, input logic f7b0);
    in_valid = 1'b1;
    ALUOp    = op;
    opb5     = b5;
    funct3   = f3;
    funct7b5 = f7b5;
    funct7b0 = f7b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7b5;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3,
                              input logic f7b5, input logic [3:0] code, input logic ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7b5 = f7b5; v.code = code; v.ill = ill;
    return v;
  endfunction

  initial begin
    int edges;
    int busy_cycles;
    logic seen_valid;

    // R-type sweep (opb5=1), then branch/reserved/ADD classes
    vecs.push_back(mk(2'b10, 3'b000, 1'b0, 4'b0000, 1'b0)); // ADD
    vecs.push_back(mk(2'b10, 3'b000, 1'b1, 4'b0001, 1'b0)); // SUB
    vecs.push_back(mk(2'b10, 3'b001, 1'b0, 4'b0110, 1'b0)); // SLL
    vecs.push_back(mk(2'b10, 3'b010, 1'b0, 4'b0101, 1'b0)); // SLT
    vecs.push_back(mk(2'b10, 3'b011, 1'b0, 4'b1001, 1'b0)); // SLTU
    vecs.push_back(mk(2'b10, 3'b100, 1'b0, 4'b0100, 1'b0)); // XOR
    vecs.push_back(mk(2'b10, 3'b101, 1'b0, 4'b0111, 1'b0)); // SRL
    vecs.push_back(mk(2'b10, 3'b101, 1'b1, 4'b1000, 1'b0)); // SRA
    vecs.push_back(mk(2'b10, 3'b110, 1'b0, 4'b0011, 1'b0)); // OR
    vecs.push_back(mk(2'b10, 3'b111, 1'b0, 4'b0010, 1'b0)); // AND
    vecs.push_back(mk(2'b01, 3'b110, 1'b0, 4'b1001, 1'b0)); // BR SLTU
    vecs.push_back(mk(2'b01, 3'b011, 1'b0, 4'b0001, 1'b1)); // BR illegal
    vecs.push_back(mk(2'b01, 3'b000, 1'b0, 4'b0001, 1'b0)); // BR SUB
    vecs.push_back(mk(2'b01, 3'b101, 1'b0, 4'b0101, 1'b0)); // BR SLT
    vecs.push_back(mk(2'b11, 3'b000, 1'b0, 4'b0000, 1'b1)); // reserved
    vecs.push_back(mk(2'b00, 3'b111, 1'b1, 4'b0000, 1'b0)); // ADD class

    // Reset state
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_md_op", {31'd0, md_op}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_ctrl", {28'd0, ALUControl}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back decode, one result per cycle
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].op, 1'b1, vecs[i].f3, vecs[i].f7b5, 1'b0);
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_ctrl", i), {28'd0, ALUControl}, {28'd0, vecs[i].code});
      check($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
      check($sformatf("vec%0d_md", i), {31'd0, md_op}, 32'd0);
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("sweep_drain", {31'd0, out_valid}, 32'd0);

    // MUL latency, input changes during WAIT are ignored
    out_ready = 1'b0;
    drive(2'b10, 1'b1, 3'b000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    funct3   = 3'b100;
    check("mul_busy", {31'd0, busy}, 32'd1);
    check("mul_in_ready", {31'd0, in_ready}, 32'd0);
    check("mul_no_valid", {31'd0, out_valid}, 32'd0);
    edges = 1;
    busy_cycles = 0;
    while (!out_valid && edges < 100) begin
      if (busy) busy_cycles++;
      tick();
      edges++;
    end
    check("mul_latency", edges, 32'd4);
    check("mul_busy_cycles", busy_cycles, 32'd3);
    check("mul_ctrl", {28'd0, ALUControl}, 32'hA);
    check("mul_md", {31'd0, md_op}, 32'd1);

    // Backpressure in HOLD with a pending request
    drive(2'b10, 1'b1, 3'b000, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp%0d_ctrl", c), {28'd0, ALUControl}, 32'hA);
      check($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_ctrl", {28'd0, ALUControl}, 32'h1);
    check("bp_next_md", {31'd0, md_op}, 32'd0);
    in_valid = 1'b0;
    tick();

    // DIV latency
    drive(2'b10, 1'b1, 3'b100, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 200) begin
      tick();
      edges++;
    end
    check("div_latency", edges, 32'd33);
    check("div_ctrl", {28'd0, ALUControl}, 32'hB);
    check("div_md", {31'd0, md_op}, 32'd1);
    tick();
    check("div_drain", {31'd0, out_valid}, 32'd0);

    // Reset during WAIT aborts the op
    drive(2'b10, 1'b1, 3'b000, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rst_wait_busy", {31'd0, busy}, 32'd0);
    tick();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("rst_wait_no_output", {31'd0, seen_valid}, 32'd0);

    // Reset during HOLD clears outputs immediately
    out_ready = 1'b0;
    drive(2'b10, 1'b1, 3'b110, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("pre_rst_hold_ctrl", {28'd0, ALUControl}, 32'h3);
    reset = 1'b1;
    #1;
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_ctrl", {28'd0, ALUControl}, 32'd0);
    tick();
    reset = 1'b0;
    drive(2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("post_rst_add_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_add_ctrl", {28'd0, ALUControl}, 32'd0);
    check("post_rst_add_illegal", {31'd0, illegal}, 32'd0);
    tick();

    // MEXT=0 build decodes M encodings as base R-type
    ALUOp = 2'b10; opb5 = 1'b1; funct3 = 3'b000; funct7b5 = 1'b0; funct7b0 = 1'b1;
    m0_in_valid = 1'b1;
    tick();
    check("m0_add_valid", {31'd0, m0_out_valid}, 32'd1);
    check("m0_add_ctrl", {28'd0, m0_ALUControl}, 32'd0);
    check("m0_add_md", {31'd0, m0_md_op}, 32'd0);
    funct3 = 3'b100;
    tick();
    m0_in_valid = 1'b0;
    check("m0_xor_ctrl", {28'd0, m0_ALUControl}, 32'h4);
    check("m0_xor_busy", {31'd0, m0_busy}, 32'd0);
    check("m0_xor_illegal", {31'd0, m0_illegal}, 32'd0);
    tick();
    check("m0_drain", {31'd0, m0_out_valid}, 32'd0);
    check("m0_in_ready", {31'd0, m0_in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_alu_ctrl_unit
`default_nettype wire
